// File: rtl/shift_pkg.sv
// Shared definitions for the shift_register / shift_deserializer pair.
package shift_pkg;

  // Deserializer FSM states; S_PAR is only reachable when PARITY_CHECK_EN is defined.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_PAR   = 2'd2
  } deser_state_e;

  // Mode codes of the companion shift_register.
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_LEFT  = 2'd1,
    MODE_RIGHT = 2'd2,
    MODE_LOAD  = 2'd3
  } shift_mode_e;

endpackage

// File: rtl/deser_bit_counter.sv
// Bit counter for shift_deserializer: counts accepted bits modulo Terminal and
// flags the bit that completes a word.
module deser_bit_counter #(
  parameter int unsigned Terminal = 8,
  parameter int unsigned CntW     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_i,
  input  logic            accept_i,
  output logic [CntW-1:0] count_o,
  output logic            last_bit_o
);

  logic [CntW-1:0] count_q, count_d;

  assign last_bit_o = accept_i && (count_q == CntW'(Terminal - 1));
  assign count_o    = count_q;

  // Next count: clear wins, otherwise advance and wrap on the last bit.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (accept_i) begin
      count_d = last_bit_o ? '0 : count_q + CntW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with one word of valid/ready output buffering.
// Optional feature: define PARITY_CHECK_EN to append an even-parity bit to
// each word and report mismatches on parity_err.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned Terminal = WIDTH + 1;
`else
  localparam int unsigned Terminal = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(Terminal + 1);

  deser_state_e    state_q;
  logic [WIDTH-1:0] sr_q, sr_shifted, word, dout_q;
  logic            dout_valid_q, overrun_q, parity_err_q;
  logic [CntW-1:0] count;
  logic            accept, data_accept, data_last, word_done, par_fail;

  // clr discards any bit presented alongside it.
  assign accept = bit_valid && !clr;

  deser_bit_counter #(
    .Terminal (Terminal),
    .CntW     (CntW)
  ) u_bit_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (clr),
    .accept_i   (accept),
    .count_o    (count),
    .last_bit_o (word_done)
  );

  assign data_last = accept && (count == CntW'(WIDTH - 1));

  // Shift direction: MSB-first enters at the LSB so the first bit ends up on top.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shifted = {sr_q[WIDTH-2:0], bit_in};
    end else begin
      sr_shifted = {bit_in, sr_q[WIDTH-1:1]};
    end
  end

  // Word source and parity check; with parity the data is already in sr_q
  // when the parity bit arrives, and the parity bit never enters the register.
  always_comb begin
`ifdef PARITY_CHECK_EN
    data_accept = accept && (state_q != S_PAR);
    word        = sr_q;
    par_fail    = word_done && (^{sr_q, bit_in});
`else
    data_accept = accept;
    word        = sr_shifted;
    par_fail    = 1'b0;
`endif
  end

  // FSM, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else if (clr) begin
      state_q      <= S_IDLE;
      sr_q         <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE:  if (accept) state_q <= S_SHIFT;
`ifdef PARITY_CHECK_EN
        S_SHIFT: if (data_last) state_q <= S_PAR;
`else
        S_SHIFT: if (data_last) state_q <= S_IDLE;
`endif
        S_PAR:   if (accept) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

      if (data_accept) begin
        sr_q <= sr_shifted;
      end

      // A held, unconsumed word blocks the new one; the new one is dropped.
      overrun_q    <= word_done && dout_valid_q && !dout_ready;
      parity_err_q <= par_fail;

      if (word_done && (!dout_valid_q || dout_ready)) begin
        dout_q       <= word;
        dout_valid_q <= 1'b1;
      end else if (dout_ready) begin
        dout_valid_q <= 1'b0;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (count != '0);
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule
